// File: rtl/vo_pkg.sv
// rtl/vo_pkg.sv - keypoint record and field widths shared by the VO pipeline stages
package vo_pkg;

  localparam int KEY_SIN_W   = 12;
  localparam int KEY_COS_W   = 12;
  localparam int KEY_COOR_W  = 10;
  localparam int KEY_SCORE_W = 8;
  localparam int KEY_DEPTH_W = 16;
  localparam int CNT_W       = 16;

  typedef struct packed {
    logic [KEY_SIN_W-1:0]   sin;
    logic [KEY_COS_W-1:0]   cos;
    logic [KEY_COOR_W-1:0]  coor_x;
    logic [KEY_COOR_W-1:0]  coor_y;
    logic [KEY_SCORE_W-1:0] score;
    logic [KEY_DEPTH_W-1:0] depth;
  } keypoint_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/raster_cnt.sv
// rtl/raster_cnt.sv - window-centre x/y raster counters with wrap and last-pixel flag
module raster_cnt
  import vo_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_adv,
  output logic [KEY_COOR_W-1:0] o_x,
  output logic [KEY_COOR_W-1:0] o_y,
  output logic                  o_last
);

  localparam logic [KEY_COOR_W-1:0] X_MAX = KEY_COOR_W'(WIDTH - 1);
  localparam logic [KEY_COOR_W-1:0] Y_MAX = KEY_COOR_W'(HEIGHT - 1);

  logic [KEY_COOR_W-1:0] r_x;
  logic [KEY_COOR_W-1:0] r_y;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_adv) begin
      if (r_x == X_MAX) begin
        r_x <= '0;
        r_y <= (r_y == Y_MAX) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = (r_x == X_MAX) && (r_y == Y_MAX);

endmodule

// File: rtl/key_fetch_ctrl.sv
// rtl/key_fetch_ctrl.sv - keypoint buffer reader: raster compare, pop, output register, flush
module key_fetch_ctrl
  import vo_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_frame_start,
  input  logic                   i_valid,
  input  logic [KEY_SIN_W-1:0]   i_key_sin,
  input  logic [KEY_COS_W-1:0]   i_key_cos,
  input  logic [KEY_COOR_W-1:0]  i_key_coor_x,
  input  logic [KEY_COOR_W-1:0]  i_key_coor_y,
  input  logic [KEY_SCORE_W-1:0] i_key_score,
  input  logic [KEY_DEPTH_W-1:0] i_key_depth,
  output logic                   o_hit,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [KEY_SIN_W-1:0]   o_sin,
  output logic [KEY_COS_W-1:0]   o_cos,
  output logic [KEY_COOR_W-1:0]  o_coor_x,
  output logic [KEY_COOR_W-1:0]  o_coor_y,
  output logic [KEY_SCORE_W-1:0] o_score,
  output logic [KEY_DEPTH_W-1:0] o_depth,
  output logic                   o_busy,
  output logic [CNT_W-1:0]       o_drop_cnt,
  output logic [CNT_W-1:0]       o_miss_cnt
);

  fetch_state_t          r_state;
  logic                  r_hit;
  logic                  r_valid;
  keypoint_t             r_key;
  logic [CNT_W-1:0]      r_drop;
  logic [CNT_W-1:0]      r_miss;

  logic [KEY_COOR_W-1:0] w_x;
  logic [KEY_COOR_W-1:0] w_y;
  logic                  w_last;
  logic                  w_adv;
  logic                  w_head_valid;
  logic                  w_match;
  logic                  w_stale;
  keypoint_t             w_head;

  assign w_adv = i_valid && (r_state == ST_SCAN) && !i_frame_start;

  raster_cnt #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_raster (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_frame_start),
    .i_adv   (w_adv),
    .o_x     (w_x),
    .o_y     (w_y),
    .o_last  (w_last)
  );

  assign w_head       = '{sin: i_key_sin, cos: i_key_cos, coor_x: i_key_coor_x,
                          coor_y: i_key_coor_y, score: i_key_score, depth: i_key_depth};
  assign w_head_valid = (i_key_score != '0);
  assign w_match      = i_valid && (i_key_coor_x == w_x) && (i_key_coor_y == w_y);
  assign w_stale      = (i_key_coor_y < w_y) || ((i_key_coor_y == w_y) && (i_key_coor_x < w_x));

  // A cycle with r_hit set is blank: the buffer head has not shifted yet.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_hit   <= 1'b0;
      r_valid <= 1'b0;
      r_key   <= '0;
      r_drop  <= '0;
      r_miss  <= '0;
    end else begin
      r_hit <= 1'b0;
      if (r_valid && i_ready) r_valid <= 1'b0;
      if (i_frame_start) begin
        r_state <= ST_SCAN;
      end else begin
        case (r_state)
          ST_SCAN: begin
            if (!r_hit && w_head_valid) begin
              if (w_match) begin
                r_hit <= 1'b1;
                if (!r_valid || i_ready) begin
                  r_valid <= 1'b1;
                  r_key   <= w_head;
                end else begin
                  r_drop <= sat_inc(r_drop);
                end
              end else if (w_stale) begin
                r_hit  <= 1'b1;
                r_miss <= sat_inc(r_miss);
              end
            end
            if (i_valid && w_last) r_state <= ST_FLUSH;
          end
          ST_FLUSH: begin
            if (!r_hit) begin
              if (w_head_valid) begin
                r_hit  <= 1'b1;
                r_miss <= sat_inc(r_miss);
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_hit      = r_hit;
  assign o_valid    = r_valid;
  assign o_sin      = r_key.sin;
  assign o_cos      = r_key.cos;
  assign o_coor_x   = r_key.coor_x;
  assign o_coor_y   = r_key.coor_y;
  assign o_score    = r_key.score;
  assign o_depth    = r_key.depth;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_drop_cnt = r_drop;
  assign o_miss_cnt = r_miss;

endmodule

// File: tb/tb_key_fetch_ctrl.sv
// tb/tb_key_fetch_ctrl.sv - directed self-checking bench for key_fetch_ctrl on an 8x4 frame
module tb_key_fetch_ctrl;
  import vo_pkg::*;

  logic                   i_clk;
  logic                   i_rst_n;
  logic                   i_frame_start;
  logic                   i_valid;
  logic [KEY_SIN_W-1:0]   i_key_sin;
  logic [KEY_COS_W-1:0]   i_key_cos;
  logic [KEY_COOR_W-1:0]  i_key_coor_x;
  logic [KEY_COOR_W-1:0]  i_key_coor_y;
  logic [KEY_SCORE_W-1:0] i_key_score;
  logic [KEY_DEPTH_W-1:0] i_key_depth;
  logic                   o_hit;
  logic                   o_valid;
  logic                   i_ready;
  logic [KEY_SIN_W-1:0]   o_sin;
  logic [KEY_COS_W-1:0]   o_cos;
  logic [KEY_COOR_W-1:0]  o_coor_x;
  logic [KEY_COOR_W-1:0]  o_coor_y;
  logic [KEY_SCORE_W-1:0] o_score;
  logic [KEY_DEPTH_W-1:0] o_depth;
  logic                   o_busy;
  logic [CNT_W-1:0]       o_drop_cnt;
  logic [CNT_W-1:0]       o_miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  keypoint_t q[$];

  key_fetch_ctrl #(.WIDTH(8), .HEIGHT(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_start(i_frame_start), .i_valid(i_valid),
    .i_key_sin(i_key_sin), .i_key_cos(i_key_cos), .i_key_coor_x(i_key_coor_x),
    .i_key_coor_y(i_key_coor_y), .i_key_score(i_key_score), .i_key_depth(i_key_depth),
    .o_hit(o_hit), .o_valid(o_valid), .i_ready(i_ready), .o_sin(o_sin), .o_cos(o_cos),
    .o_coor_x(o_coor_x), .o_coor_y(o_coor_y), .o_score(o_score), .o_depth(o_depth),
    .o_busy(o_busy), .o_drop_cnt(o_drop_cnt), .o_miss_cnt(o_miss_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic keypoint_t kp(input int x, input int y, input int s);
    keypoint_t k;
    k.sin    = KEY_SIN_W'(12'h100 + x);
    k.cos    = KEY_COS_W'(12'h200 + y);
    k.coor_x = KEY_COOR_W'(x);
    k.coor_y = KEY_COOR_W'(y);
    k.score  = KEY_SCORE_W'(s);
    k.depth  = KEY_DEPTH_W'(16'hB000 + x * 16 + y);
    return k;
  endfunction

  // Model buffer: head is front of q (zeros when empty); o_hit pops it.
  task automatic tick(input logic v);
    keypoint_t h;
    h = (q.size() > 0) ? q[0] : '0;
    i_valid = v;
    i_key_sin = h.sin; i_key_cos = h.cos; i_key_coor_x = h.coor_x;
    i_key_coor_y = h.coor_y; i_key_score = h.score; i_key_depth = h.depth;
    @(posedge i_clk); #1;
    if (o_hit && q.size() > 0) void'(q.pop_front());
  endtask

  task automatic frame_start();
    i_frame_start = 1'b1;
    tick(1'b0);
    i_frame_start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if (o_hit !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_flags: hit=%0b valid=%0b busy=%0b want 0 0 0", o_hit, o_valid, o_busy); end
    n_tests++; if (o_coor_x !== '0 || o_coor_y !== '0 || o_depth !== '0 || o_score !== '0) begin n_fail++; $display("FAIL reset_data: x=%0d y=%0d depth=%0h score=%0d want 0", o_coor_x, o_coor_y, o_depth, o_score); end
    n_tests++; if (o_drop_cnt !== 16'd0 || o_miss_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: drop=%0d miss=%0d want 0 0", o_drop_cnt, o_miss_cnt); end
    @(negedge i_clk); i_rst_n = 1'b1;
  endtask

  task automatic test_hit();
    int hits = 0;
    q.delete(); q.push_back(kp(3, 1, 5)); i_ready = 1'b1;
    frame_start();
    n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL hit_busy: got %0b want 1", o_busy); end
    for (int p = 0; p < 11; p++) begin tick(1'b1); hits += int'(o_hit); end
    n_tests++; if (hits != 0) begin n_fail++; $display("FAIL hit_early: got %0d pops want 0", hits); end
    tick(1'b1);
    n_tests++; if (o_hit !== 1'b1 || o_valid !== 1'b1) begin n_fail++; $display("FAIL hit_pulse: hit=%0b valid=%0b want 1 1", o_hit, o_valid); end
    n_tests++; if (o_coor_x !== 10'd3 || o_coor_y !== 10'd1 || o_score !== 8'd5 || o_depth !== 16'hB031 || o_sin !== 12'h103 || o_cos !== 12'h201) begin
      n_fail++; $display("FAIL hit_data: x=%0d y=%0d s=%0d d=%0h sin=%0h cos=%0h want 3 1 5 b031 103 201", o_coor_x, o_coor_y, o_score, o_depth, o_sin, o_cos);
    end
    tick(1'b0);
    n_tests++; if (o_hit !== 1'b0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL hit_single: hit=%0b valid=%0b want 0 0", o_hit, o_valid); end
  endtask

  task automatic test_back_to_back();
    q.delete(); q.push_back(kp(2, 0, 5)); q.push_back(kp(3, 0, 6)); i_ready = 1'b1;
    frame_start();
    tick(1'b1); tick(1'b1); tick(1'b1);
    n_tests++; if (o_hit !== 1'b1 || o_coor_x !== 10'd2 || o_coor_y !== 10'd0) begin n_fail++; $display("FAIL b2b_first: hit=%0b x=%0d y=%0d want 1 2 0", o_hit, o_coor_x, o_coor_y); end
    tick(1'b1);
    n_tests++; if (o_hit !== 1'b0) begin n_fail++; $display("FAIL b2b_blank: hit=%0b want 0", o_hit); end
    tick(1'b1);
    n_tests++; if (o_hit !== 1'b1 || o_miss_cnt !== 16'd1 || o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_miss: hit=%0b miss=%0d valid=%0b want 1 1 0", o_hit, o_miss_cnt, o_valid); end
  endtask

  task automatic test_drop();
    int hits = 0;
    q.delete(); q.push_back(kp(1, 0, 7)); q.push_back(kp(5, 0, 8)); i_ready = 1'b0;
    frame_start();
    for (int p = 0; p < 6; p++) begin tick(1'b1); hits += int'(o_hit); end
    n_tests++; if (hits != 2) begin n_fail++; $display("FAIL drop_hits: got %0d want 2", hits); end
    n_tests++; if (o_valid !== 1'b1 || o_coor_x !== 10'd1 || o_score !== 8'd7) begin n_fail++; $display("FAIL drop_hold: valid=%0b x=%0d s=%0d want 1 1 7", o_valid, o_coor_x, o_score); end
    n_tests++; if (o_drop_cnt !== 16'd1 || o_miss_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_cnt: drop=%0d miss=%0d want 1 1", o_drop_cnt, o_miss_cnt); end
    i_ready = 1'b1;
    tick(1'b0);
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL drop_accept: valid=%0b want 0", o_valid); end
  endtask

  task automatic test_stale_and_flush();
    int hits = 0;
    bit [7:0] pat = '0;
    q.delete(); i_ready = 1'b1;
    frame_start();
    for (int p = 0; p < 20; p++) tick(1'b1);
    q.push_back(kp(0, 0, 3));
    tick(1'b0);
    n_tests++; if (o_hit !== 1'b1 || o_valid !== 1'b0 || o_miss_cnt !== 16'd2) begin n_fail++; $display("FAIL stale: hit=%0b valid=%0b miss=%0d want 1 0 2", o_hit, o_valid, o_miss_cnt); end
    q.push_back(kp(7, 3, 4)); q.push_back(kp(1, 1, 9)); q.push_back(kp(2, 2, 9)); q.push_back(kp(0, 3, 9));
    tick(1'b0);
    for (int p = 20; p < 31; p++) begin tick(1'b1); hits += int'(o_hit); end
    n_tests++; if (hits != 0) begin n_fail++; $display("FAIL flush_early: got %0d pops want 0", hits); end
    tick(1'b1);
    n_tests++; if (o_hit !== 1'b1 || o_valid !== 1'b1 || o_coor_x !== 10'd7 || o_coor_y !== 10'd3 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL last_pixel: hit=%0b valid=%0b x=%0d y=%0d busy=%0b want 1 1 7 3 1", o_hit, o_valid, o_coor_x, o_coor_y, o_busy);
    end
    for (int t = 0; t < 7; t++) begin tick(1'b0); pat[t] = o_hit; end
    n_tests++; if (pat[6:0] !== 7'b0101010) begin n_fail++; $display("FAIL flush_pattern: got %07b want 0101010", pat[6:0]); end
    n_tests++; if (o_busy !== 1'b1 || o_miss_cnt !== 16'd5) begin n_fail++; $display("FAIL flush_cnt: busy=%0b miss=%0d want 1 5", o_busy, o_miss_cnt); end
    tick(1'b0);
    n_tests++; if (o_busy !== 1'b0 || o_hit !== 1'b0) begin n_fail++; $display("FAIL flush_idle: busy=%0b hit=%0b want 0 0", o_busy, o_hit); end
  endtask

  task automatic test_reset_mid_frame();
    q.delete(); q.push_back(kp(0, 0, 9)); i_ready = 1'b0;
    frame_start();
    tick(1'b1);
    n_tests++; if (o_valid !== 1'b1 || o_hit !== 1'b1) begin n_fail++; $display("FAIL mid_pre: valid=%0b hit=%0b want 1 1", o_valid, o_hit); end
    #2 i_rst_n = 1'b0;
    #1;
    n_tests++; if (o_valid !== 1'b0 || o_hit !== 1'b0 || o_busy !== 1'b0 || o_coor_x !== '0 || o_miss_cnt !== '0 || o_drop_cnt !== '0) begin
      n_fail++; $display("FAIL mid_reset: valid=%0b hit=%0b busy=%0b x=%0d miss=%0d drop=%0d want all 0", o_valid, o_hit, o_busy, o_coor_x, o_miss_cnt, o_drop_cnt);
    end
    @(negedge i_clk); i_rst_n = 1'b1;
    q.delete(); q.push_back(kp(0, 0, 9)); i_ready = 1'b1;
    frame_start();
    tick(1'b1);
    n_tests++; if (o_hit !== 1'b1 || o_valid !== 1'b1 || o_coor_x !== 10'd0 || o_coor_y !== 10'd0 || o_score !== 8'd9) begin
      n_fail++; $display("FAIL mid_restart: hit=%0b valid=%0b x=%0d y=%0d s=%0d want 1 1 0 0 9", o_hit, o_valid, o_coor_x, o_coor_y, o_score);
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_frame_start = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_key_sin = '0; i_key_cos = '0; i_key_coor_x = '0; i_key_coor_y = '0;
    i_key_score = '0; i_key_depth = '0;
    test_reset();
    test_hit();
    test_back_to_back();
    test_drop();
    test_stale_and_flush();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_fetch_ctrl.md
# key_fetch_ctrl

Reader side of the keypoint buffer: tracks the raster position of the BRIEF window centre, compares it with the keypoint at the buffer head, and pulses the buffer's pop (`hit`) input when that keypoint is consumed or stale. Consumed keypoints go into an output register with a valid/ready handshake towards descriptor generation. At end of frame the block flushes leftover buffer entries and counts every drop and miss.

## Interface
Parameters:
- `WIDTH`, 640: pixels per line; x range 0..WIDTH-1.
- `HEIGHT`, 480: lines per frame; y range 0..HEIGHT-1.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_frame_start`  in  1  one-cycle pulse; next `i_valid` is pixel (0,0).
- `i_valid`  in  1  window centre advances one pixel this cycle.
- `i_key_sin`, `i_key_cos`  in  12 each  head keypoint orientation.
- `i_key_coor_x`, `i_key_coor_y`  in  10 each  head keypoint position.
- `i_key_score`  in  8  head score; 0 means buffer head is empty.
- `i_key_depth`  in  16  head depth.
- `o_hit`  out  1  pop request to the buffer, registered.
- `o_valid`  out  1  output keypoint register holds data.
- `i_ready`  in  1  downstream accepts when `o_valid && i_ready`.
- `o_sin`, `o_cos`  out  12 each  latched keypoint orientation.
- `o_coor_x`, `o_coor_y`  out  10 each  latched position.
- `o_score`  out  8  latched score.
- `o_depth`  out  16  latched depth.
- `o_busy`  out  1  state is not IDLE.
- `o_drop_cnt`  out  16  matches lost because output register was full; saturating.
- `o_miss_cnt`  out  16  stale or flushed entries popped without match; saturating.

## Operation
- States: IDLE, SCAN, FLUSH. Reset → IDLE. `i_frame_start` in any state → SCAN, with raster (x,y)=(0,0). Counters are not cleared.
- Raster: in SCAN, each `i_valid` advances x; wrap at WIDTH-1 to 0 and increment y. Accepting (WIDTH-1,HEIGHT-1) → FLUSH.
- Head valid: `i_key_score != 0`.
- Blank cycle: any cycle with `o_hit`=1. No compare happens, because the buffer has not shifted yet. Pops are therefore at most one every 2 cycles.
- SCAN, non-blank cycle, head valid:
  - Match: `i_valid` and head == (x,y).
    - Set `o_hit` next cycle.
    - If `!o_valid || i_ready`: load the head fields into the output register and set `o_valid`.
    - Otherwise increment `o_drop_cnt`; the output register is unchanged.
  - Stale: head_y < y, or head_y == y and head_x < x, regardless of `i_valid`. Set `o_hit` and increment `o_miss_cnt`.
  - Head ahead of raster: no action.
- FLUSH, non-blank cycle: head valid → `o_hit` and `o_miss_cnt`+1; head invalid → IDLE.
- Output handshake: `o_valid` clears on `i_ready` unless a new load happens in the same cycle (load wins). Data is stable while `o_valid && !i_ready`.
- Counters saturate at 16'hFFFF.
- IDLE: no compare, `o_hit`=0.

## Timing
- Reset values: `o_hit`=0, `o_valid`=0, all data outputs 0, `o_busy`=0, both counters 0, raster (0,0).
- Compare → `o_hit` high: 1 cycle. Compare → `o_valid` high: 1 cycle, aligned with `o_hit`.
- `o_hit` is always a single-cycle pulse, never high two cycles in a row.
- Match on the last pixel: pop issued, state → FLUSH in the same edge; the first FLUSH cycle is blank.
- `i_frame_start` together with a pending compare: frame start wins; the compare is skipped that cycle.
- Reset asserted mid-frame: immediate return to reset values. Buffer contents are untouched.

## Structure
- Shared package `vo_pkg`: `keypoint_t` struct (sin, cos, coor_x, coor_y, score, depth; 68 bits) and the `KEY_*_W` width constants, shared with the keypoint buffer and the BRIEF stage.
- One sub-module, `raster_cnt`: x/y counters with wrap and `last` flag, parameterised by WIDTH/HEIGHT.
- FSM, compare logic and output register live in the top level.

## Test plan
- WIDTH=8, HEIGHT=4. Head (3,1), score 5, `i_ready`=1 → `o_hit` and `o_valid` pulse 1 cycle after pixel 11; `o_coor_x`=3, `o_coor_y`=1.
- Heads (2,0) and (3,0) back to back → first matched; (3,0) is missed because its compare falls in the blank cycle → `o_miss_cnt`=1.
- `i_ready`=0 held, matches at (1,0) then (5,0) → output keeps (1,0); `o_drop_cnt`=1; two `o_hit` pulses.
- Head (0,0) presented mid-frame at raster (4,2) → stale pop, `o_miss_cnt`+1, `o_valid` stays 0.
- End of frame with 3 valid entries left → 3 `o_hit` pulses 2 cycles apart in FLUSH, `o_miss_cnt`+3; score-0 head → IDLE, `o_busy`=0.
- Reset asserted in SCAN with `o_valid`=1 → all outputs 0 immediately; `i_frame_start` after release restarts the raster at (0,0).
